// File: rtl/dds_sin_gen.sv
// Phase-accumulator sine/square/triangle generator driving an external quarter-wave LUT.
// Frequency and mode changes are deferred to period boundaries so the output never glitches.
module dds_sin_gen #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 8,
  parameter int LUT_DW  = 8,
  parameter int OUT_W   = LUT_DW + 1
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         mode,
  output logic [LUT_AW-1:0]  lut_addr,
  input  logic [LUT_DW-1:0]  lut_data,
  output logic [OUT_W-1:0]   sin_out,
  output logic               sin_valid,
  output logic               busy,
  output logic               wrap_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t             state;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] freq_q;
  logic [PHASE_W-1:0] acc_next;
  logic [1:0]         mode_q;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  addr_field;
  logic [LUT_DW-1:0]  mag;
  logic [LUT_DW-1:0]  tri_mag;
  logic [OUT_W-1:0]   mag_ext;
  logic [OUT_W-1:0]   sample;
  logic               wrap;

  assign quad       = acc[PHASE_W-1 -: 2];
  assign addr_field = acc[PHASE_W-3 -: LUT_AW];
  // Odd quadrants read the quarter-wave table backwards.
  assign lut_addr   = quad[0] ? ~addr_field : addr_field;
  assign {wrap, acc_next} = {1'b0, acc} + {1'b0, freq_q};
  assign busy       = (state != IDLE);

  generate
    if (LUT_AW >= LUT_DW) begin : g_tri_trunc
      assign tri_mag = lut_addr[LUT_AW-1 -: LUT_DW];
    end else begin : g_tri_pad
      assign tri_mag = {lut_addr, {(LUT_DW-LUT_AW){1'b0}}};
    end
  endgenerate

  always_comb begin
    mag = lut_data;
    case (mode_q)
      2'd1:    mag = '1;
      2'd2:    mag = tri_mag;
      default: mag = lut_data;
    endcase
  end

  // Magnitude tops out at 2^LUT_DW-1, so negation can never reach the most negative code.
  always_comb begin
    mag_ext               = '0;
    mag_ext[LUT_DW-1:0]   = mag;
    sample                = quad[1] ? ('0 - mag_ext) : mag_ext;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= IDLE;
      acc        <= '0;
      freq_q     <= '0;
      mode_q     <= '0;
      sin_out    <= '0;
      sin_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc        <= '0;
          freq_q     <= freq_word;
          mode_q     <= mode;
          sin_out    <= '0;
          sin_valid  <= 1'b0;
          wrap_pulse <= 1'b0;
          if (en) state <= RUN;
        end
        RUN, STOP: begin
          acc        <= acc_next;
          sin_out    <= sample;
          sin_valid  <= 1'b1;
          wrap_pulse <= wrap;
          if (state == RUN) begin
            if (wrap) begin
              freq_q <= freq_word;
              mode_q <= mode;
            end
            if (!en) begin
              if (wrap) begin
                state <= IDLE;
                acc   <= '0;
              end else begin
                state <= STOP;
              end
            end
          end else begin
            // Re-enable wins over finishing the period, so phase stays continuous.
            if (en) begin
              state <= RUN;
            end else if (wrap || freq_q == '0) begin
              state <= IDLE;
              acc   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
